// File: rtl/csi2_pkt_sequencer_pkg.sv
// Shared definitions for the CSI-2 packet sequencer slice.
// Contents:
//   DT_FS/DT_FE/DT_LS/DT_LE : short-packet data type codes
//   seq_state_e             : sequencer FSM state encoding
//   pkt_kind_e              : which packet the sequencer is currently handling
//   next_frame_num          : frame number advance with wrap to 1 (0 when counting is off)
//   next_line_num           : line number advance with 16-bit wrap to 1 (never 0)
package csi2_pkt_sequencer_pkg;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SP_REQ,
    ST_LP_REQ,
    ST_WAIT
  } seq_state_e;

  typedef enum logic [2:0] {
    PK_FS,
    PK_FE,
    PK_LS,
    PK_LP,
    PK_LE
  } pkt_kind_e;

  // A maximum of zero disables frame numbering entirely: the field stays 0.
  function automatic logic [15:0] next_frame_num(input logic [15:0] cur,
                                                 input logic [15:0] max_num);
    if (max_num == 16'd0) begin
      return 16'd0;
    end else if (cur >= max_num) begin
      return 16'd1;
    end else begin
      return cur + 16'd1;
    end
  endfunction

  // Line number 0 is reserved for "no line yet", so the wrap skips it.
  function automatic logic [15:0] next_line_num(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? 16'd1 : cur + 16'd1;
  endfunction

endpackage

// File: rtl/csi2_pkt_sequencer_if.sv
// Request bus between the packet sequencer and the CSI-2 header builder.
// Signals (named from the sequencer's point of view):
//   vc_o            2  virtual channel of the current packet
//   dt_o            6  data type of the current packet
//   wc_o            16 word count (long) or frame/line number (short)
//   sp_req_o        1  single-cycle short-packet request
//   lp_req_o        1  single-cycle long-packet request
//   phdr_xfr_done_i 1  single-cycle pulse from the builder: packet fully sent
// Modports: master = sequencer, slave = header builder.
interface csi2_pkt_sequencer_if;

  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic        sp_req_o;
  logic        lp_req_o;
  logic        phdr_xfr_done_i;

  modport master (
    output vc_o, dt_o, wc_o, sp_req_o, lp_req_o,
    input  phdr_xfr_done_i
  );

  modport slave (
    input  vc_o, dt_o, wc_o, sp_req_o, lp_req_o,
    output phdr_xfr_done_i
  );

endinterface

// File: rtl/csi2_pkt_sequencer_evt_detect.sv
// Frame/line timing event detector for the CSI-2 packet sequencer.
// Turns fv/lv edges into pending-event flags that the sequencer consumes one at
// a time, and flags an overflow when an event arrives while its flag is still set.
// Ports:
//   core_clk_i, core_rst : clock, asynchronous active-high reset
//   fv_i, lv_i           : frame valid / line valid from the sensor timing
//   clr_fs_i/ln_i/fe_i   : sequencer has issued the request for that event
//   fs_pend_o/ln_pend_o/fe_pend_o : pending frame start / line / frame end
//   ovf_err_o            : sticky, an event was dropped
module csi2_pkt_sequencer_evt_detect (
  input  logic core_clk_i,
  input  logic core_rst,
  input  logic fv_i,
  input  logic lv_i,
  input  logic clr_fs_i,
  input  logic clr_ln_i,
  input  logic clr_fe_i,
  output logic fs_pend_o,
  output logic ln_pend_o,
  output logic fe_pend_o,
  output logic ovf_err_o
);

  logic fv_q, lv_q;
  logic fs_pend_q, ln_pend_q, fe_pend_q, ovf_q;
  logic fs_pend_d, ln_pend_d, fe_pend_d, ovf_d;
  logic fv_rise, fv_fall, lv_rise;

  // A line start only counts inside a frame; stray lv pulses are dropped silently.
  // A new edge wins over a same-cycle clear, so the event is re-armed rather than
  // lost, and only an edge hitting a flag that stays set is an overflow.
  always_comb begin
    fv_rise   = fv_i & ~fv_q;
    fv_fall   = ~fv_i & fv_q;
    lv_rise   = lv_i & ~lv_q & fv_i;
    fs_pend_d = fv_rise | (fs_pend_q & ~clr_fs_i);
    ln_pend_d = lv_rise | (ln_pend_q & ~clr_ln_i);
    fe_pend_d = fv_fall | (fe_pend_q & ~clr_fe_i);
    ovf_d     = ovf_q
              | (fv_rise & fs_pend_q & ~clr_fs_i)
              | (lv_rise & ln_pend_q & ~clr_ln_i)
              | (fv_fall & fe_pend_q & ~clr_fe_i);
  end

  always_ff @(posedge core_clk_i or posedge core_rst) begin
    if (core_rst) begin
      fv_q      <= 1'b0;
      lv_q      <= 1'b0;
      fs_pend_q <= 1'b0;
      ln_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      fv_q      <= fv_i;
      lv_q      <= lv_i;
      fs_pend_q <= fs_pend_d;
      ln_pend_q <= ln_pend_d;
      fe_pend_q <= fe_pend_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fs_pend_o = fs_pend_q;
  assign ln_pend_o = ln_pend_q;
  assign fe_pend_o = fe_pend_q;
  assign ovf_err_o = ovf_q;

endmodule

// File: rtl/csi2_pkt_sequencer.sv
// CSI-2 packet sequencer: upstream control stage of the packet header builder.
// Converts frame/line valid timing into an ordered stream of packet requests
// (FS, optional LS, long packet, optional LE, FE) and waits for the builder's
// done pulse after each one.
// Ports:
//   core_clk_i, core_rst : clock, asynchronous active-high reset
//   vc_cfg_i, wc_cfg_i   : virtual channel / long-packet word count, latched at FS
//   fv_i, lv_i           : frame valid / line valid
//   hdr                  : request bus to the header builder (master side)
//   busy_o               : a request is outstanding
//   ovf_err_o            : sticky, a timing event was dropped
module csi2_pkt_sequencer
  import csi2_pkt_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CNT_MAX = 2,
  parameter bit          LINE_SYNC_EN  = 1'b0,
  parameter logic [5:0]  PIX_DT        = 6'h2B
) (
  input  logic                 core_clk_i,
  input  logic                 core_rst,
  input  logic [1:0]           vc_cfg_i,
  input  logic [15:0]          wc_cfg_i,
  input  logic                 fv_i,
  input  logic                 lv_i,
  csi2_pkt_sequencer_if.master hdr,
  output logic                 busy_o,
  output logic                 ovf_err_o
);

  localparam logic [15:0] FRAME_MAX = 16'(FRAME_CNT_MAX);

  seq_state_e  state_q, state_d;
  pkt_kind_e   kind_q, kind_d;
  logic [1:0]  vc_q, vc_d, vc_lat_q, vc_lat_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d, wc_lat_q, wc_lat_d;
  logic [15:0] frame_num_q, frame_num_d, line_num_q, line_num_d;
  logic        clr_fs, clr_ln, clr_fe;
  logic        fs_pend, ln_pend, fe_pend;

  csi2_pkt_sequencer_evt_detect u_evt (
    .core_clk_i (core_clk_i),
    .core_rst   (core_rst),
    .fv_i       (fv_i),
    .lv_i       (lv_i),
    .clr_fs_i   (clr_fs),
    .clr_ln_i   (clr_ln),
    .clr_fe_i   (clr_fe),
    .fs_pend_o  (fs_pend),
    .ln_pend_o  (ln_pend),
    .fe_pend_o  (fe_pend),
    .ovf_err_o  (ovf_err_o)
  );

  always_ff @(posedge core_clk_i or posedge core_rst) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
      kind_q  <= PK_FS;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // Next-state logic also computes the packet fields, so they are registered
  // together with the transition into a REQ state and stay put through WAIT.
  // Arbitration is fixed FS > line > FE so a frame end never overtakes a line.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    vc_lat_d    = vc_lat_q;
    wc_lat_d    = wc_lat_q;
    frame_num_d = frame_num_q;
    line_num_d  = line_num_q;
    clr_fs      = 1'b0;
    clr_ln      = 1'b0;
    clr_fe      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fs_pend) begin
          clr_fs      = 1'b1;
          frame_num_d = next_frame_num(frame_num_q, FRAME_MAX);
          line_num_d  = 16'd0;
          vc_lat_d    = vc_cfg_i;
          wc_lat_d    = wc_cfg_i;
          state_d     = ST_SP_REQ;
          kind_d      = PK_FS;
          vc_d        = vc_cfg_i;
          dt_d        = DT_FS;
          wc_d        = frame_num_d;
        end else if (ln_pend) begin
          clr_ln     = 1'b1;
          line_num_d = next_line_num(line_num_q);
          vc_d       = vc_lat_q;
          if (LINE_SYNC_EN) begin
            state_d = ST_SP_REQ;
            kind_d  = PK_LS;
            dt_d    = DT_LS;
            wc_d    = line_num_d;
          end else begin
            state_d = ST_LP_REQ;
            kind_d  = PK_LP;
            dt_d    = PIX_DT;
            wc_d    = wc_lat_q;
          end
        end else if (fe_pend) begin
          clr_fe  = 1'b1;
          state_d = ST_SP_REQ;
          kind_d  = PK_FE;
          vc_d    = vc_lat_q;
          dt_d    = DT_FE;
          wc_d    = frame_num_q;
        end
      end
      ST_SP_REQ, ST_LP_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A line with sync packets chains LS -> LP -> LE without passing IDLE.
        if (hdr.phdr_xfr_done_i) begin
          state_d = ST_IDLE;
          if (kind_q == PK_LS) begin
            state_d = ST_LP_REQ;
            kind_d  = PK_LP;
            dt_d    = PIX_DT;
            wc_d    = wc_lat_q;
          end else if (kind_q == PK_LP && LINE_SYNC_EN) begin
            state_d = ST_SP_REQ;
            kind_d  = PK_LE;
            dt_d    = DT_LE;
            wc_d    = line_num_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk_i or posedge core_rst) begin
    if (core_rst) begin
      vc_q        <= 2'd0;
      dt_q        <= 6'd0;
      wc_q        <= 16'd0;
      vc_lat_q    <= 2'd0;
      wc_lat_q    <= 16'd0;
      frame_num_q <= 16'd0;
      line_num_q  <= 16'd0;
    end else begin
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      vc_lat_q    <= vc_lat_d;
      wc_lat_q    <= wc_lat_d;
      frame_num_q <= frame_num_d;
      line_num_q  <= line_num_d;
    end
  end

  always_comb begin
    hdr.sp_req_o = (state_q == ST_SP_REQ);
    hdr.lp_req_o = (state_q == ST_LP_REQ);
    hdr.vc_o     = vc_q;
    hdr.dt_o     = dt_q;
    hdr.wc_o     = wc_q;
    busy_o       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_csi2_pkt_sequencer.sv
// Testbench for csi2_pkt_sequencer.
// Two instances share the same sensor timing: dut0 without line sync packets,
// dut1 with them. Stimulus pushes the expected packets into one queue per
// instance; a monitor pops and compares whenever a request appears, and a
// responder per instance plays the header builder's done pulse.
module tb_csi2_pkt_sequencer;

  localparam int         MAXF = 2;
  localparam logic [5:0] PIX  = 6'h2B;

  localparam int EV_FS    = 0;
  localparam int EV_LINE  = 1;
  localparam int EV_FE    = 2;
  localparam int EV_PULSE = 3;
  localparam int EV_DROP  = 4;

  typedef struct packed {
    logic        isLong;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
  } pkt_t;

  logic        coreClk;
  logic        coreRst;
  logic [1:0]  vcCfg;
  logic [15:0] wcCfg;
  logic        fv;
  logic        lv;
  logic        busy0, busy1, ovf0, ovf1;

  int checks;
  int errors;
  int doneDelay;

  pkt_t expQ0[$];
  pkt_t expQ1[$];

  logic [15:0] mFrame, mLine, mWc;
  logic [1:0]  mVc;

  csi2_pkt_sequencer_if hdr0();
  csi2_pkt_sequencer_if hdr1();

  csi2_pkt_sequencer #(.FRAME_CNT_MAX(MAXF), .LINE_SYNC_EN(1'b0), .PIX_DT(PIX)) dut0 (
    .core_clk_i (coreClk),
    .core_rst   (coreRst),
    .vc_cfg_i   (vcCfg),
    .wc_cfg_i   (wcCfg),
    .fv_i       (fv),
    .lv_i       (lv),
    .hdr        (hdr0),
    .busy_o     (busy0),
    .ovf_err_o  (ovf0)
  );

  csi2_pkt_sequencer #(.FRAME_CNT_MAX(MAXF), .LINE_SYNC_EN(1'b1), .PIX_DT(PIX)) dut1 (
    .core_clk_i (coreClk),
    .core_rst   (coreRst),
    .vc_cfg_i   (vcCfg),
    .wc_cfg_i   (wcCfg),
    .fv_i       (fv),
    .lv_i       (lv),
    .hdr        (hdr1),
    .busy_o     (busy1),
    .ovf_err_o  (ovf1)
  );

  // Free-running core clock, 10 time units per cycle.
  initial begin
    coreClk = 1'b0;
    forever #5 coreClk = ~coreClk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge coreClk);
    #1;
  endtask

  // Reference model: frame start bumps the frame number (wrapping to 1),
  // restarts line numbering and captures the channel configuration.
  task automatic modelFrameStart(input logic [1:0] vc, input logic [15:0] wc);
    pkt_t p;
    if (MAXF == 0) mFrame = 16'd0;
    else if (mFrame == 16'(MAXF)) mFrame = 16'd1;
    else mFrame = mFrame + 16'd1;
    mLine = 16'd0;
    mVc   = vc;
    mWc   = wc;
    p = '{isLong: 1'b0, vc: mVc, dt: 6'h00, wc: mFrame};
    expQ0.push_back(p);
    expQ1.push_back(p);
  endtask

  // A line is one long packet; with line sync it is framed by LS and LE carrying the line number.
  task automatic modelLine();
    pkt_t lp;
    mLine = (mLine == 16'hFFFF) ? 16'd1 : mLine + 16'd1;
    lp = '{isLong: 1'b1, vc: mVc, dt: PIX, wc: mWc};
    expQ0.push_back(lp);
    expQ1.push_back('{isLong: 1'b0, vc: mVc, dt: 6'h02, wc: mLine});
    expQ1.push_back(lp);
    expQ1.push_back('{isLong: 1'b0, vc: mVc, dt: 6'h03, wc: mLine});
  endtask

  task automatic modelFrameEnd();
    pkt_t p;
    p = '{isLong: 1'b0, vc: mVc, dt: 6'h01, wc: mFrame};
    expQ0.push_back(p);
    expQ1.push_back(p);
  endtask

  // Drives one sensor timing event and records what the sequencer must produce for it.
  task automatic applyStimulus(input int evt);
    case (evt)
      EV_FS: begin
        vcCfg = 2'($urandom);
        wcCfg = 16'($urandom_range(1, 65535));
        fv    = 1'b1;
        modelFrameStart(vcCfg, wcCfg);
      end
      EV_LINE: begin
        lv = 1'b1;
        modelLine();
        tick(3);
        lv = 1'b0;
      end
      EV_FE: begin
        fv = 1'b0;
        modelFrameEnd();
      end
      EV_PULSE: begin
        lv = 1'b1;
        modelLine();
        tick(1);
        lv = 1'b0;
        tick(1);
      end
      EV_DROP: begin
        lv = 1'b1;
        tick(1);
        lv = 1'b0;
        tick(1);
      end
      default: ;
    endcase
  endtask

  task automatic scoreboardPop(input int idx, input logic isLong, input logic [1:0] vc,
                               input logic [5:0] dt, input logic [15:0] wc, input logic busy);
    pkt_t exp;
    pkt_t act;
    string nm;
    nm  = (idx == 0) ? "dut0" : "dut1";
    act = '{isLong: isLong, vc: vc, dt: dt, wc: wc};
    checkOutput({nm, "_busy_on_req"}, 32'(busy), 32'd1);
    if ((idx == 0 && expQ0.size() == 0) || (idx == 1 && expQ1.size() == 0)) begin
      checkOutput({nm, "_unexpected_pkt"}, 32'(act), 32'hFFFFFFFF);
    end else begin
      exp = (idx == 0) ? expQ0.pop_front() : expQ1.pop_front();
      checkOutput({nm, "_pkt"}, 32'(act), 32'(exp));
    end
  endtask

  // Monitor: every request seen on the falling edge is matched against the head of the queue.
  always @(negedge coreClk) begin
    if (!coreRst) begin
      if (hdr0.sp_req_o || hdr0.lp_req_o) begin
        if (hdr0.sp_req_o && hdr0.lp_req_o) checkOutput("dut0_both_req", 32'd1, 32'd0);
        scoreboardPop(0, hdr0.lp_req_o, hdr0.vc_o, hdr0.dt_o, hdr0.wc_o, busy0);
      end
      if (hdr1.sp_req_o || hdr1.lp_req_o) begin
        if (hdr1.sp_req_o && hdr1.lp_req_o) checkOutput("dut1_both_req", 32'd1, 32'd0);
        scoreboardPop(1, hdr1.lp_req_o, hdr1.vc_o, hdr1.dt_o, hdr1.wc_o, busy1);
      end
    end
  end

  function automatic int pickDelay();
    return (doneDelay == 0) ? int'($urandom_range(1, 6)) : doneDelay;
  endfunction

  // Header builder stand-in for dut0: done pulse a chosen number of cycles after each request.
  initial begin
    hdr0.phdr_xfr_done_i = 1'b0;
    forever begin
      if (hdr0.sp_req_o || hdr0.lp_req_o) begin
        repeat (pickDelay()) @(posedge coreClk);
        #1 hdr0.phdr_xfr_done_i = 1'b1;
        @(posedge coreClk);
        #1 hdr0.phdr_xfr_done_i = 1'b0;
      end else begin
        @(posedge coreClk);
        #1;
      end
    end
  end

  // Header builder stand-in for dut1, same timing policy.
  initial begin
    hdr1.phdr_xfr_done_i = 1'b0;
    forever begin
      if (hdr1.sp_req_o || hdr1.lp_req_o) begin
        repeat (pickDelay()) @(posedge coreClk);
        #1 hdr1.phdr_xfr_done_i = 1'b1;
        @(posedge coreClk);
        #1 hdr1.phdr_xfr_done_i = 1'b0;
      end else begin
        @(posedge coreClk);
        #1;
      end
    end
  end

  // Main sequence: directed scenarios first, then randomized frames, then drain and summarize.
  initial begin
    checks    = 0;
    errors    = 0;
    doneDelay = 4;
    mFrame    = 16'd0;
    mLine     = 16'd0;
    mVc       = 2'd0;
    mWc       = 16'd0;
    coreRst   = 1'b1;
    fv        = 1'b0;
    lv        = 1'b0;
    vcCfg     = 2'd0;
    wcCfg     = 16'd0;
    tick(3);
    checkOutput("reset_dut0", {4'd0, hdr0.vc_o, hdr0.dt_o, hdr0.wc_o, hdr0.sp_req_o, hdr0.lp_req_o, busy0, ovf0}, 32'd0);
    checkOutput("reset_dut1", {4'd0, hdr1.vc_o, hdr1.dt_o, hdr1.wc_o, hdr1.sp_req_o, hdr1.lp_req_o, busy1, ovf1}, 32'd0);
    coreRst = 1'b0;
    tick(5);

    // Three frames of two lines; the second frame changes its config mid-frame.
    for (int f = 0; f < 3; f++) begin
      applyStimulus(EV_FS);
      tick(30);
      if (f == 1) begin
        wcCfg = ~wcCfg;
        vcCfg = vcCfg + 2'd1;
      end
      for (int l = 0; l < 2; l++) begin
        applyStimulus(EV_LINE);
        tick(30);
      end
      applyStimulus(EV_FE);
      tick(30);
    end

    // Frame and line starts one cycle apart while the builder is slow.
    doneDelay = 20;
    applyStimulus(EV_FS);
    tick(1);
    applyStimulus(EV_LINE);
    tick(120);
    checkOutput("ovf0_fs_lv_close", 32'(ovf0), 32'd0);
    checkOutput("ovf1_fs_lv_close", 32'(ovf1), 32'd0);
    applyStimulus(EV_FE);
    tick(60);

    // A second line and the frame end both queue up behind a busy line.
    applyStimulus(EV_FS);
    tick(60);
    applyStimulus(EV_LINE);
    tick(5);
    applyStimulus(EV_LINE);
    applyStimulus(EV_FE);
    tick(200);
    checkOutput("ovf0_fe_behind_line", 32'(ovf0), 32'd0);

    // Three line starts in quick succession: the third finds its flag set and is lost.
    applyStimulus(EV_FS);
    tick(60);
    applyStimulus(EV_PULSE);
    applyStimulus(EV_PULSE);
    applyStimulus(EV_DROP);
    tick(200);
    checkOutput("ovf0_sticky", 32'(ovf0), 32'd1);
    checkOutput("ovf1_sticky", 32'(ovf1), 32'd1);
    applyStimulus(EV_FE);
    tick(60);

    // Reset while a frame start is waiting for its done pulse.
    applyStimulus(EV_FS);
    tick(8);
    coreRst = 1'b1;
    fv      = 1'b0;
    tick(1);
    checkOutput("rst_wait_dut0", {4'd0, hdr0.vc_o, hdr0.dt_o, hdr0.wc_o, hdr0.sp_req_o, hdr0.lp_req_o, busy0, ovf0}, 32'd0);
    checkOutput("rst_wait_dut1", {4'd0, hdr1.vc_o, hdr1.dt_o, hdr1.wc_o, hdr1.sp_req_o, hdr1.lp_req_o, busy1, ovf1}, 32'd0);
    expQ0.delete();
    expQ1.delete();
    mFrame = 16'd0;
    mLine  = 16'd0;
    tick(2);
    coreRst = 1'b0;
    tick(30);
    applyStimulus(EV_FS);
    tick(40);
    applyStimulus(EV_LINE);
    tick(100);
    applyStimulus(EV_FE);
    tick(40);

    // Randomized frames with random line counts and builder latency.
    doneDelay = 0;
    for (int f = 0; f < 4; f++) begin
      applyStimulus(EV_FS);
      tick($urandom_range(30, 40));
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        applyStimulus(EV_LINE);
        tick($urandom_range(30, 40));
      end
      applyStimulus(EV_FE);
      tick($urandom_range(30, 40));
    end

    for (int i = 0; i < 400 && (expQ0.size() != 0 || expQ1.size() != 0); i++) tick(1);
    checkOutput("drain_q0", 32'(expQ0.size()), 32'd0);
    checkOutput("drain_q1", 32'(expQ1.size()), 32'd0);
    checkOutput("ovf0_final", 32'(ovf0), 32'd0);
    checkOutput("ovf1_final", 32'(ovf1), 32'd0);
    checkOutput("busy_final", {30'd0, busy1, busy0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
